// File: rtl/decode_pkg.sv
// Shared constants and types for the RV32I decode stage.
// Ports: none (package). Provides opcode constants, one-hot type bit indices,
// ALU op encodings, the decoded bundle type and an XLEN legality check.
package decode_pkg;

  // Major opcodes (instr[6:0])
  localparam logic [6:0] OP_R      = 7'h33;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;

  // Bit positions inside the one-hot type vector {r,i,s,b,u,j}
  localparam int T_R = 5;
  localparam int T_I = 4;
  localparam int T_S = 3;
  localparam int T_B = 2;
  localparam int T_U = 1;
  localparam int T_J = 0;

  // ALU op encodings that are not derived from funct3/funct7
  localparam logic [3:0] ALU_ADD    = 4'b0000;
  localparam logic [3:0] ALU_BRANCH = 4'b0001;

  typedef struct packed {
    logic [5:0] typ;
    logic [3:0] alu_op;
    logic       rd_we;
    logic       illegal;
  } dec_t;

  function automatic bit xlen_ok(int xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

endpackage

// File: rtl/decode_if.sv
// Handshake + decoded-bundle bus between fetch, decode and execute.
// Ports: in_valid/in_ready/in_instr/in_pc from fetch; out_* towards execute.
// slave = decode stage, master = fetch/execute side driving it.
interface decode_if #(
  parameter int XLEN = 32,
  parameter int PC_W = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [PC_W-1:0] in_pc;

  logic            out_valid;
  logic            out_ready;
  logic [5:0]      out_type;
  logic [3:0]      out_alu_op;
  logic [6:0]      out_opcode;
  logic [2:0]      out_funct3;
  logic [6:0]      out_funct7;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [4:0]      out_rd;
  logic [XLEN-1:0] out_imm;
  logic            out_rd_we;
  logic            out_illegal;
  logic [PC_W-1:0] out_pc;

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_type, out_alu_op, out_opcode, out_funct3,
           out_funct7, out_rs1, out_rs2, out_rd, out_imm, out_rd_we,
           out_illegal, out_pc
  );

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_type, out_alu_op, out_opcode, out_funct3,
           out_funct7, out_rs1, out_rs2, out_rd, out_imm, out_rd_we,
           out_illegal, out_pc
  );
endinterface

// File: rtl/decode_logic.sv
// Combinational RV32I decoder: instruction word -> type/alu_op/rd_we/illegal + immediate.
// Latency: 0 cycles (pure combinational). Backpressure: none, no state.
// Ports: instr_i (32b word), dec_o (decoded bundle), imm_o (XLEN sign-extended immediate).
module decode_logic
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr_i,
  output dec_t            dec_o,
  output logic [XLEN-1:0] imm_o
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] imm32;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];

  always_comb begin
    dec_o = '0;
    imm32 = '0;
    if (instr_i[1:0] != 2'b11) begin
      dec_o.illegal = 1'b1;
    end else begin
      case (opcode)
        OP_R: begin
          dec_o.typ[T_R] = 1'b1;
          dec_o.alu_op   = {funct3, instr_i[30]};
        end
        OP_IMM: begin
          dec_o.typ[T_I] = 1'b1;
          imm32          = {{20{instr_i[31]}}, instr_i[31:20]};
          // only SRAI/SRLI use instr[30] as an op selector; elsewhere it is immediate data
          dec_o.alu_op   = {funct3, (funct3 == 3'b101) & instr_i[30]};
        end
        OP_LOAD, OP_JALR: begin
          dec_o.typ[T_I] = 1'b1;
          imm32          = {{20{instr_i[31]}}, instr_i[31:20]};
          dec_o.alu_op   = ALU_ADD;
        end
        OP_STORE: begin
          dec_o.typ[T_S] = 1'b1;
          imm32          = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
          dec_o.alu_op   = ALU_ADD;
        end
        OP_BRANCH: begin
          dec_o.typ[T_B] = 1'b1;
          imm32          = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                            instr_i[30:25], instr_i[11:8], 1'b0};
          dec_o.alu_op   = ALU_BRANCH;
        end
        OP_LUI, OP_AUIPC: begin
          dec_o.typ[T_U] = 1'b1;
          imm32          = {instr_i[31:12], 12'b0};
          dec_o.alu_op   = ALU_ADD;
        end
        OP_JAL: begin
          dec_o.typ[T_J] = 1'b1;
          imm32          = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                            instr_i[20], instr_i[30:21], 1'b0};
          dec_o.alu_op   = ALU_ADD;
        end
        default: dec_o.illegal = 1'b1;
      endcase
    end
    dec_o.rd_we = (dec_o.typ[T_R] | dec_o.typ[T_I] | dec_o.typ[T_U] | dec_o.typ[T_J])
                  && (instr_i[11:7] != 5'd0);
  end

  // Every format fits in 32 bits with instr[31] as the sign, so widen once here.
  assign imm_o = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_pipe.sv
// Handshaked decode stage: decodes on the input side, registers into main reg M, 2-entry with skid S.
// Latency: 1 cycle accept -> out_valid; 1 instr/cycle sustained while out_ready is high.
// Backpressure: stalled M holds outputs stable, one extra input parks in S; in_ready = !S.valid.
// Ports: clk, rst_n (async, active low), flush (sync kill), bus (decode_if.slave).
module decode_pipe
  import decode_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    flush,
  decode_if.slave bus
);

  if (!xlen_ok(XLEN)) begin : g_bad_xlen
    $error("decode_pipe: XLEN must be 32 or 64");
  end

  typedef struct packed {
    logic [31:0]     instr;
    logic [PC_W-1:0] pc;
    dec_t            dec;
    logic [XLEN-1:0] imm;
  } entry_t;

  dec_t            in_dec;
  logic [XLEN-1:0] in_imm;
  entry_t          in_ent;
  entry_t          m_q, m_d, s_q, s_d;
  logic            m_vld_q, m_vld_d, s_vld_q, s_vld_d;
  logic            accept, advance;

  decode_logic #(.XLEN(XLEN)) u_decode_logic (
    .instr_i (bus.in_instr),
    .dec_o   (in_dec),
    .imm_o   (in_imm)
  );

  assign in_ent  = {bus.in_instr, bus.in_pc, in_dec, in_imm};
  assign accept  = bus.in_valid && !s_vld_q;
  assign advance = !m_vld_q || bus.out_ready;

  always_comb begin
    m_d     = m_q;
    s_d     = s_q;
    m_vld_d = m_vld_q;
    s_vld_d = s_vld_q;
    if (flush) begin
      // kill wins over both accept and advance; incoming entry is dropped
      m_vld_d = 1'b0;
      s_vld_d = 1'b0;
    end else if (advance) begin
      if (s_vld_q) begin
        // S full implies in_ready was low, so no input competes for M here
        m_d     = s_q;
        m_vld_d = 1'b1;
        s_vld_d = 1'b0;
      end else begin
        m_vld_d = accept;
        if (accept) m_d = in_ent;
      end
    end else if (accept) begin
      s_d     = in_ent;
      s_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q     <= '0;
      s_q     <= '0;
      m_vld_q <= 1'b0;
      s_vld_q <= 1'b0;
    end else begin
      m_q     <= m_d;
      s_q     <= s_d;
      m_vld_q <= m_vld_d;
      s_vld_q <= s_vld_d;
    end
  end

  assign bus.in_ready    = !s_vld_q;
  assign bus.out_valid   = m_vld_q;
  assign bus.out_type    = m_q.dec.typ;
  assign bus.out_alu_op  = m_q.dec.alu_op;
  assign bus.out_rd_we   = m_q.dec.rd_we;
  assign bus.out_illegal = m_q.dec.illegal;
  assign bus.out_imm     = m_q.imm;
  assign bus.out_pc      = m_q.pc;
  assign bus.out_opcode  = m_q.instr[6:0];
  assign bus.out_funct3  = m_q.instr[14:12];
  assign bus.out_funct7  = m_q.instr[31:25];
  assign bus.out_rs1     = m_q.instr[19:15];
  assign bus.out_rs2     = m_q.instr[24:20];
  assign bus.out_rd      = m_q.instr[11:7];

endmodule
